// File: rtl/vreaction_arbiter_if.sv
// Handshake/status bundle between a reaction-game controller and its host.
interface vreaction_arbiter_if;
   logic       start;
   logic       reset;
   logic [2:0] btn;
   logic       lamp;
   logic       busy;
   logic [1:0] winner;
   logic       winner_valid;
   logic       false_start;
   logic [9:0] reaction_ms;

   modport master (
      output start, reset, btn,
      input  lamp, busy, winner, winner_valid, false_start, reaction_ms
   );

   modport slave (
      input  start, reset, btn,
      output lamp, busy, winner, winner_valid, false_start, reaction_ms
   );
endinterface

// File: rtl/vreaction_arbiter.sv
// Three-player reaction game: random delay, lamp, round-robin press arbitration,
// false-start detection and millisecond reaction timing.
module vreaction_arbiter #(
   parameter int TICK_DIV  = 50000,
   parameter int DELAY_MIN = 500,
   parameter int MAX_MS    = 999
) (
   input logic                clk,
   input logic                async_nreset,
   vreaction_arbiter_if.slave bus
);
   localparam int DIV_W = $clog2(TICK_DIV);
   localparam int DLY_W = $clog2(DELAY_MIN + 256);

   typedef enum logic [2:0] {IDLE, ARMED, GO, DONE, FOUL} state_t;

   state_t           state, state_nxt;
   logic [7:0]       lfsr;
   logic [2:0]       btn_q, rise;
   logic [1:0]       ptr, pick;
   logic [DIV_W-1:0] div;
   logic [DLY_W-1:0] cnt, dly;
   logic [1:0]       winner;
   logic             winner_valid;
   logic [9:0]       rms;
   logic             tick, any_press, dly_hit, to_hit;

   function automatic logic [1:0] wrap3(input logic [2:0] s);
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   assign rise      = bus.btn & ~btn_q;
   assign any_press = |rise;
   assign tick      = (div == DIV_W'(TICK_DIV - 1));
   assign dly_hit   = tick && ((cnt + DLY_W'(1)) >= dly);
   assign to_hit    = tick && ((rms + 10'd1) == 10'(MAX_MS));

   // Walk from ptr upward with wrap; the last hit written is the closest to ptr.
   always_comb begin
      pick = 2'd3;
      for (int k = 2; k >= 0; k--) begin
         if (rise[wrap3({1'b0, ptr} + 3'(k))]) pick = wrap3({1'b0, ptr} + 3'(k));
      end
   end

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) state <= IDLE;
      else               state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.reset) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (bus.start) state_nxt = ARMED;
            ARMED:   if (any_press) state_nxt = FOUL;
                     else if (dly_hit) state_nxt = GO;
            GO:      if (any_press || to_hit) state_nxt = DONE;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         lfsr         <= 8'h01;
         btn_q        <= 3'b111;
         ptr          <= 2'd0;
         div          <= '0;
         cnt          <= '0;
         dly          <= '0;
         winner       <= 2'd3;
         winner_valid <= 1'b0;
         rms          <= '0;
      end else begin
         lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         btn_q <= bus.btn;
         div   <= tick ? '0 : div + DIV_W'(1);
         if (bus.reset) begin
            winner       <= 2'd3;
            winner_valid <= 1'b0;
            rms          <= '0;
         end else begin
            case (state)
               IDLE: if (bus.start) begin
                  dly          <= DLY_W'(DELAY_MIN) + DLY_W'(lfsr);
                  div          <= '0;
                  cnt          <= '0;
                  winner       <= 2'd3;
                  winner_valid <= 1'b0;
                  rms          <= '0;
               end
               ARMED: begin
                  if (any_press) begin
                     winner <= pick;
                  end else if (dly_hit) begin
                     cnt <= '0;
                     div <= '0;
                  end else if (tick) begin
                     cnt <= cnt + DLY_W'(1);
                  end
               end
               // A press wins over a coincident tick, so reaction_ms stays frozen.
               GO: begin
                  if (any_press) begin
                     winner       <= pick;
                     winner_valid <= 1'b1;
                     ptr          <= wrap3({1'b0, pick} + 3'd1);
                  end else if (tick) begin
                     rms <= rms + 10'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.lamp         = (state == GO);
   assign bus.busy         = (state == ARMED) || (state == GO);
   assign bus.false_start  = (state == FOUL);
   assign bus.winner       = winner;
   assign bus.winner_valid = winner_valid;
   assign bus.reaction_ms  = rms;
endmodule

// File: tb/tb_vreaction_arbiter.sv
// Directed plus randomized rounds against a cycle-count model of the game rules.
module tb_vreaction_arbiter;
   localparam int T    = 4;
   localparam int DMIN = 2;
   localparam int MAXM = 10;

   logic clk = 1'b0;
   logic async_nreset = 1'b0;

   vreaction_arbiter_if bus();

   vreaction_arbiter #(.TICK_DIV(T), .DELAY_MIN(DMIN), .MAX_MS(MAXM)) dut (
      .clk          (clk),
      .async_nreset (async_nreset),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   int         ptr_m = 0;
   logic [7:0] m_lfsr;
   logic       saw_lamp;

   // Feedback is the parity of the tap bits for x^8, x^6, x^5, x^4.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], ^(v & 8'hB8)};
   endfunction

   always @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) m_lfsr <= 8'h01;
      else               m_lfsr <= lfsr_next(m_lfsr);
   end

   function automatic int arb(input logic [2:0] m, input int p);
      for (int k = 0; k < 3; k++) if (m[(p + k) % 3]) return (p + k) % 3;
      return 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int w, input int wv, input int fs,
                          input int rms, input int lamp, input int busy);
      chk({tag, ".winner"},       32'(bus.winner),       w);
      chk({tag, ".winner_valid"}, 32'(bus.winner_valid), wv);
      chk({tag, ".false_start"},  32'(bus.false_start),  fs);
      chk({tag, ".reaction_ms"},  32'(bus.reaction_ms),  rms);
      chk({tag, ".lamp"},         32'(bus.lamp),         lamp);
      chk({tag, ".busy"},         32'(bus.busy),         busy);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.lamp === 1'b1) saw_lamp = 1'b1;
      end
   endtask

   // kind 0: press in ARMED cycle `at`; kind 1: press in GO cycle `at`; kind 2: no press.
   task automatic round(input int kind, input logic [2:0] mask, input int at, input string tag);
      int d, w, wv, fs, rms;
      d = DMIN + int'(m_lfsr);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      chk({tag, ".armed_busy"}, 32'(bus.busy), 1);
      saw_lamp = 1'b0;
      if (kind == 0) begin
         step(at);
         bus.btn = mask;
         step(1);
         w = arb(mask, ptr_m); wv = 0; fs = 1; rms = 0;
         chk({tag, ".lamp_seen"}, 32'(saw_lamp), 0);
      end else begin
         step(d * T - 1);
         chk({tag, ".lamp_early"}, 32'(saw_lamp), 0);
         step(1);
         chk({tag, ".lamp_on"}, 32'(bus.lamp), 1);
         if (kind == 1 && at < MAXM * T) begin
            step(at);
            bus.btn = mask;
            step(1);
            w = arb(mask, ptr_m); wv = 1; fs = 0; rms = at / T;
            ptr_m = (w + 1) % 3;
         end else begin
            step(MAXM * T - 1);
            chk({tag, ".lamp_last"}, 32'(bus.lamp), 1);
            step(1);
            w = 3; wv = 0; fs = 0; rms = MAXM;
         end
      end
      chk_out({tag, ".result"}, w, wv, fs, rms, 0, 0);
      bus.start = 1'b1;
      step(3);
      bus.start = 1'b0;
      chk_out({tag, ".hold"}, w, wv, fs, rms, 0, 0);
      bus.reset = 1'b1;
      step(1);
      bus.reset = 1'b0;
      bus.btn   = 3'b000;
      chk_out({tag, ".sreset"}, 3, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int d, kind, at;
      logic [2:0] m;
      logic found;
      bus.start = 1'b0;
      bus.reset = 1'b0;
      bus.btn   = 3'b000;
      repeat (2) @(negedge clk);
      chk_out("por", 3, 0, 0, 0, 0, 0);
      async_nreset = 1'b1;

      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (m_lfsr == 8'h03) found = 1'b1;
         else step(1);
      end
      if (!found) begin
         n_err++;
         $display("FAIL lfsr_sync: observed no 8'h03 within 300 cycles, expected one");
      end

      round(1, 3'b010, 12, "go_btn1");
      round(0, 3'b100, 7, "foul_btn2");
      round(2, 3'b000, 0, "timeout");

      async_nreset = 1'b0;
      step(1);
      async_nreset = 1'b1;
      ptr_m = 0;
      round(1, 3'b101, 5, "rr_first");
      round(1, 3'b101, 9, "rr_second");

      bus.btn = 3'b011;
      step(2);
      round(2, 3'b000, 0, "held_btn");

      d = DMIN + int'(m_lfsr);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      step(d * T + 6);
      chk("mid_go.lamp", 32'(bus.lamp), 1);
      chk("mid_go.rms", 32'(bus.reaction_ms), 1);
      #1 async_nreset = 1'b0;
      #1;
      chk_out("async_mid_go", 3, 0, 0, 0, 0, 0);
      ptr_m = 0;
      @(negedge clk);
      async_nreset = 1'b1;

      for (int r = 0; r < 12; r++) begin
         step($urandom_range(0, 6));
         d    = DMIN + int'(m_lfsr);
         kind = $urandom_range(0, 2);
         m    = 3'($urandom_range(1, 7));
         at   = (kind == 0) ? $urandom_range(0, d * T - 1) : $urandom_range(0, MAXM * T + 3);
         round(kind, m, at, $sformatf("rnd%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
